// File: rtl/operand_bank_seq.sv
// ---------------------------------------------------------------------------
// operand_bank_seq
//
// Operand source for an N-way, W-bit select mux. Holds N registers of W bits,
// presents them as one packed bus, and drives the mux select through a timed,
// handshaked scan of all N entries.
//
// Parameters:
//   N    - number of entries (N >= 2)
//   W    - entry width in bits
//   SELW - select width, derived as $clog2(N)
//
// Ports:
//   clk         - rising-edge clock
//   rst         - asynchronous, active-high reset
//   wr_en       - write strobe
//   wr_addr     - entry index to write (writes with wr_addr >= N are dropped)
//   wr_data     - write data
//   start       - request one scan of entries 0..N-1 (accepted only in IDLE)
//   hold        - stall the scan; sel stays frozen while high in SCAN
//   choicearray - packed entries, entry i at bits [i*W +: W]
//   sel         - mux select
//   sel_valid   - sel belongs to an active scan
//   busy        - sequencer is not idle
//   done        - one-cycle pulse after the last entry has been presented
// ---------------------------------------------------------------------------
module operand_bank_seq #(
  parameter  int N    = 4,
  parameter  int W    = 3,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [SELW-1:0]   wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              start,
  input  logic              hold,
  output logic [N*W-1:0]    choicearray,
  output logic [SELW-1:0]   sel,
  output logic              sel_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last index of a scan, and N widened by one bit so an out-of-range
  // address can be detected even when N is not a power of two.
  localparam logic [SELW-1:0] LAST_SEL = SELW'(N - 1);
  localparam logic [SELW:0]   N_EXT    = (SELW + 1)'(N);

  state_t            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic              sel_valid_q, sel_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N*W-1:0]    bank_q, bank_d;
  logic              wr_ok;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < N_EXT);

  // Register bank update. The bank is stored already packed, so the mux bus
  // is the flop output itself and a write shows up the cycle after its edge.
  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < N; i++) begin
      if (wr_ok && (wr_addr == SELW'(i))) begin
        bank_d[i*W +: W] = wr_data;
      end
    end
  end

  // Scan sequencer next state. sel only leaves 0 inside SCAN, and the
  // transition out of the last entry goes to DONE rather than wrapping.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (start) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!hold) begin
          if (sel_q == LAST_SEL) begin
            state_d = DONE;
            sel_d   = '0;
          end else begin
            sel_d = sel_q + SELW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        sel_d   = '0;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they can be flopped
  // alongside it, keeping every output a plain register.
  always_comb begin
    sel_valid_d = (state_d == SCAN);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bank_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bank_q      <= bank_d;
    end
  end

  assign choicearray = bank_q;
  assign sel         = sel_q;
  assign sel_valid   = sel_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_operand_bank_seq.sv
// ---------------------------------------------------------------------------
// tb_operand_bank_seq
//
// Self-checking bench for operand_bank_seq (N=4, W=3). A fixed table covers
// load and the basic scan, hand sequences cover hold, mid-scan writes and
// reset mid-scan, and a random phase is compared against a schedule-based
// reference model: an accepted start queues the whole sequence of output
// tuples the scan should present, and hold simply replays the current one.
// ---------------------------------------------------------------------------
module tb_operand_bank_seq;

  localparam int N    = 4;
  localparam int W    = 3;
  localparam int SELW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wr_en = 1'b0;
  logic [SELW-1:0]   wr_addr = '0;
  logic [W-1:0]      wr_data = '0;
  logic              start = 1'b0;
  logic              hold = 1'b0;
  logic [N*W-1:0]    choicearray;
  logic [SELW-1:0]   sel;
  logic              sel_valid;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  operand_bank_seq #(.N(N), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .hold        (hold),
    .choicearray (choicearray),
    .sel         (sel),
    .sel_valid   (sel_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Reference model: currently presented tuple plus the queued future ones.
  typedef struct {
    logic [SELW-1:0] sel;
    logic            valid;
    logic            busy;
    logic            done;
  } out_t;

  out_t          cur;
  out_t          pending[$];
  logic [W-1:0]  mem [N];

  function automatic out_t mk(input logic [SELW-1:0] s, input logic v,
                              input logic b, input logic d);
    out_t o;
    o.sel = s; o.valid = v; o.busy = b; o.done = d;
    return o;
  endfunction

  task automatic modelReset();
    cur = mk('0, 1'b0, 1'b0, 1'b0);
    pending.delete();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  task automatic modelEdge();
    if (wr_en && (int'(wr_addr) < N)) mem[wr_addr] = wr_data;
    if (cur.valid && hold) begin
      cur = cur;
    end else if (pending.size() > 0) begin
      cur = pending.pop_front();
    end else if (!cur.busy && start) begin
      cur = mk('0, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i < N; i++) pending.push_back(mk(SELW'(i), 1'b1, 1'b1, 1'b0));
      pending.push_back(mk('0, 1'b0, 1'b1, 1'b1));
    end else begin
      cur = mk('0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  function automatic logic [N*W-1:0] modelBank();
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = mem[i];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [SELW-1:0] es,
                             input logic ev, input logic eb, input logic ed,
                             input logic [N*W-1:0] ec);
    checks++;
    if (sel !== es || sel_valid !== ev || busy !== eb || done !== ed || choicearray !== ec) begin
      errors++;
      $display("[TB] FAIL %s: got sel=%0d valid=%0b busy=%0b done=%0b choice=%h, want sel=%0d valid=%0b busy=%0b done=%0b choice=%h",
               name, sel, sel_valid, busy, done, choicearray, es, ev, eb, ed, ec);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, cur.sel, cur.valid, cur.busy, cur.done, modelBank());
  endtask

  // Drive one cycle of inputs, advance the model at the edge, sample 2 ns
  // later, then return the inputs to their quiet values.
  task automatic applyStimulus(input logic we, input logic [SELW-1:0] wa,
                               input logic [W-1:0] wd, input logic st,
                               input logic hd);
    wr_en = we; wr_addr = wa; wr_data = wd; start = st; hold = hd;
    @(posedge clk);
    modelEdge();
    #2;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; hold = 1'b0;
  endtask

  typedef struct {
    logic            we;
    logic [SELW-1:0] wa;
    logic [W-1:0]    wd;
    logic            st;
    logic            hd;
    logic [SELW-1:0] es;
    logic            ev;
    logic            eb;
    logic            ed;
    logic [N*W-1:0]  ec;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int doneAt;
    int budget;

    // Load, scan, start ignored in SCAN/DONE, then a scan with hold at sel 0
    // and at the last entry (no done while held at N-1).
    vecs[0]  = '{1'b1, 2'd0, 3'b110, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 12'h006};
    vecs[1]  = '{1'b1, 2'd1, 3'b101, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 12'h02E};
    vecs[2]  = '{1'b1, 2'd2, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 12'h02E};
    vecs[3]  = '{1'b1, 2'd3, 3'b010, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 12'h42E};
    vecs[4]  = '{1'b0, 2'd0, 3'b000, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 12'h42E};
    vecs[5]  = '{1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 12'h42E};
    vecs[6]  = '{1'b0, 2'd0, 3'b000, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 12'h42E};
    vecs[7]  = '{1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 12'h42E};
    vecs[8]  = '{1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 12'h42E};
    vecs[9]  = '{1'b0, 2'd0, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 12'h42E};
    vecs[10] = '{1'b1, 2'd2, 3'b111, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 12'h5EE};
    vecs[11] = '{1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 12'h5EE};
    vecs[12] = '{1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 12'h5EE};
    vecs[13] = '{1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 12'h5EE};
    vecs[14] = '{1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 12'h5EE};
    vecs[15] = '{1'b0, 2'd0, 3'b000, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 12'h5EE};
    vecs[16] = '{1'b0, 2'd0, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 12'h5EE};

    // Asynchronous reset between edges must clear outputs immediately.
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 checkOutput("reset_async", '0, 1'b0, 1'b0, 1'b0, '0);
    modelReset();
    @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].st, vecs[i].hd);
      checkOutput($sformatf("vec%0d", i), vecs[i].es, vecs[i].ev, vecs[i].eb,
                  vecs[i].ed, vecs[i].ec);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("after_vec_idle", '0, 1'b0, 1'b0, 1'b0, 12'h5EE);

    // Hold two cycles at sel 1 with start asserted (ignored): done moves
    // from cycle N+1 to cycle N+3 after the start edge.
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkModel("hold_c1");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkModel("hold_c2");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    checkOutput("hold_c3", 2'd1, 1'b1, 1'b1, 1'b0, 12'h5EE);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1);
    checkOutput("hold_c4", 2'd1, 1'b1, 1'b1, 1'b0, 12'h5EE);
    doneAt = 0;
    for (int c = 5; c <= 12 && doneAt == 0; c++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkModel($sformatf("hold_c%0d", c));
      if (done === 1'b1) doneAt = c;
    end
    checks++;
    if (doneAt != N + 3) begin
      errors++;
      $display("[TB] FAIL hold_done_latency: got cycle %0d, want cycle %0d", doneAt, N + 3);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkModel("hold_idle");

    // Write entry 2 one edge before sel reaches 2; the mux sees it at once.
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkModel("midwr_sel0");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkModel("midwr_sel1");
    applyStimulus(1'b1, 2'd2, 3'b011, 1'b0, 1'b0);
    checks++;
    if (sel !== 2'd2 || choicearray[8:6] !== 3'b011) begin
      errors++;
      $display("[TB] FAIL midwr_visible: got sel=%0d entry2=%b, want sel=2 entry2=011", sel, choicearray[8:6]);
    end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkModel($sformatf("midwr_tail%0d", c));
    end

    // Reset while sel is 2: immediate clear, no done, then a clean scan.
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    budget = 0;
    while (sel !== 2'd2 && budget < 8) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      budget++;
    end
    checks++;
    if (sel !== 2'd2) begin
      errors++;
      $display("[TB] FAIL rstmid_reach_sel2: got sel=%0d, want 2 within 8 cycles", sel);
    end
    #2 rst = 1'b1;
    #1 checkOutput("rstmid_async", '0, 1'b0, 1'b0, 1'b0, '0);
    modelReset();
    @(posedge clk);
    #2 checkOutput("rstmid_held", '0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("rstmid_idle", '0, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("rescan_s0", 2'd0, 1'b1, 1'b1, 1'b0, '0);
    for (int c = 1; c < N; c++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput($sformatf("rescan_s%0d", c), SELW'(c), 1'b1, 1'b1, 1'b0, '0);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    checkOutput("rescan_done", '0, 1'b0, 1'b1, 1'b1, '0);

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 9) < 3), SELW'($urandom_range(0, N - 1)),
                    W'($urandom), ($urandom_range(0, 9) < 2),
                    ($urandom_range(0, 3) == 0));
      checkModel($sformatf("rand%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_bank_seq.md
# operand_bank_seq

Operand source for the N-way, W-bit select mux: holds N registers of W bits, presents them as the packed `choicearray` bus, and drives the mux `sel` through a timed scan of all N entries. Sits directly upstream of the mux; its `choicearray` and `sel` outputs feed the mux's `choicearray`/`sel` inputs one-to-one. It replaces the hand-written stimulus ramp with a synthesizable, handshaked sequencer.

## Interface
- `N`, 4, number of entries (N ≥ 2)
- `W`, 3, entry width in bits
- `SELW`, `$clog2(N)`, select width (derived; not overridden)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `wr_en`  in  1  write strobe
- `wr_addr`  in  SELW  entry index to write
- `wr_data`  in  W  write data
- `start`  in  1  request one scan of entries 0..N-1
- `hold`  in  1  stall the scan (sel frozen)
- `choicearray`  out  N*W  packed entries; entry i at bits [i*W +: W]
- `sel`  out  SELW  mux select
- `sel_valid`  out  1  `sel` is part of an active scan
- `busy`  out  1  FSM not in IDLE
- `done`  out  1  one-cycle pulse at end of scan

## Operation
- Reset (async, immediate): all entries 0, `choicearray`=0, `sel`=0, `sel_valid`=0, `busy`=0, `done`=0, FSM=IDLE.
- Write: on a clock edge with `wr_en`=1 and `wr_addr` < N, entry `wr_addr` ← `wr_data`; visible on `choicearray` the following cycle. `wr_addr` ≥ N (non-power-of-2 N): write dropped, no other entry changed.
- Writes are permitted at any time, including mid-scan; the mux sees the updated value from the next cycle.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: `sel`=0, `sel_valid`=0. `start`=1 → SCAN with `sel`=0.
  - SCAN: `sel_valid`=1. `hold`=0: if `sel`=N-1 → DONE, else `sel` ← `sel`+1. `hold`=1: stay, `sel` unchanged.
  - DONE: `done`=1, `sel_valid`=0, `sel`=0; unconditionally → IDLE.
- `start` outside IDLE is ignored (no queuing). `hold` outside SCAN has no effect.
- `sel` never exceeds N-1; no wrap inside a scan.
- `busy` = (state ≠ IDLE).
- All outputs are registered.

## Timing
- `start` sampled high at edge t (IDLE) → cycles t+1..t+N: `sel_valid`=1, `sel`=0,1,…,N-1 (no hold); cycle t+N+1: `done`=1, `busy`=1; cycle t+N+2: IDLE, earliest next `start` accepted at that edge.
- Each `hold` cycle in SCAN extends the scan by exactly one cycle.
- Write at edge t with `wr_addr`=`sel` of cycle t+1: mux sees new data in cycle t+1.
- Simultaneous `start` and `wr_en` in IDLE: both take effect.
- Simultaneous `hold`=1 and `sel`=N-1: remain at N-1, no `done`.
- `rst` asserted mid-scan: outputs go to reset values without waiting for a clock edge; the scan is abandoned and no `done` is issued; after release, FSM is IDLE.

## Test plan
- Reset: assert `rst` asynchronously between edges → `choicearray`=12'h000, `sel`=0, `sel_valid`/`busy`/`done`=0 immediately.
- Load: write entries 0..3 = 3'b110, 3'b101, 3'b000, 3'b010 → `choicearray`=12'b010000101110 one cycle after the last write.
- Scan: `start` pulse after load → `sel` 0,1,2,3 on 4 consecutive cycles with `sel_valid`=1, then `done`=1 for one cycle, `busy` low the next cycle; mux output sequence 110,101,000,010.
- Hold: `hold`=1 for 2 cycles while `sel`=1 → `sel`=1 for 3 cycles total, `done` delayed by 2 cycles; `start` during SCAN/DONE ignored.
- Mid-scan write: write entry 2 = 3'b111 one edge before `sel`=2 → `choicearray`[8:6]=3'b111 while `sel`=2; N=3 build: write to `wr_addr`=3 → no entry changes.
- Reset mid-scan: assert `rst` while `sel`=2 → all outputs 0, no `done`; new `start` after release produces full 0..3 scan.
